// File: rtl/lbist_ctrl_if.sv
// Control/status bundle between the LBIST sequencer and the LFSR, MISR and scan-enable logic.
// The master modport is the sequencer side.
interface lbist_ctrl_if #(
   parameter int unsigned N     = 24,
   parameter int unsigned PAT_W = 16
) ();
   logic             start;
   logic             abort;
   logic [PAT_W-1:0] num_patterns;
   logic [N-1:0]     golden;
   logic [N-1:0]     misr_sig;
   logic             lfsr_seed_n;
   logic             misr_seed_n;
   logic             lfsr_en;
   logic             misr_en;
   logic             scan_en;
   logic             busy;
   logic             done;
   logic             pass;
   logic [PAT_W-1:0] pat_idx;

   modport master (
      input  start, abort, num_patterns, golden, misr_sig,
      output lfsr_seed_n, misr_seed_n, lfsr_en, misr_en, scan_en, busy, done, pass, pat_idx
   );

   modport slave (
      output start, abort, num_patterns, golden, misr_sig,
      input  lfsr_seed_n, misr_seed_n, lfsr_en, misr_en, scan_en, busy, done, pass, pat_idx
   );
endinterface

// File: rtl/lbist_ctrl.sv
// LBIST STUMPS session sequencer: seed reload, P shift/capture patterns, final unload shift,
// then a signature compare. Every output is a flop because the seed lines feed async resets.
module lbist_ctrl #(
   parameter int unsigned N         = 24,
   parameter int unsigned CHAIN_LEN = 32,
   parameter int unsigned PAT_W     = 16
) (
   input  logic         clk,
   input  logic         rst,
   lbist_ctrl_if.master bus
);
   localparam int unsigned CntW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CHAIN_LEN - 1);

   typedef enum logic [2:0] {StIdle, StInit, StShift, StCapture, StCompare, StDone} state_e;

   state_e           state_q;
   logic [CntW-1:0]  cyc_cnt_q;
   logic [PAT_W-1:0] num_pat_q;
   logic [N-1:0]     golden_q;
   logic [PAT_W-1:0] pat_idx_q;
   logic             lfsr_seed_n_q, misr_seed_n_q;
   logic             lfsr_en_q, misr_en_q, scan_en_q;
   logic             busy_q, done_q, pass_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         cyc_cnt_q     <= '0;
         num_pat_q     <= '0;
         golden_q      <= '0;
         pat_idx_q     <= '0;
         lfsr_seed_n_q <= 1'b1;
         misr_seed_n_q <= 1'b1;
         lfsr_en_q     <= 1'b0;
         misr_en_q     <= 1'b0;
         scan_en_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
      end else if (bus.abort) begin
         // Abort beats a simultaneous start and also clears a finished result.
         state_q       <= StIdle;
         lfsr_seed_n_q <= 1'b1;
         misr_seed_n_q <= 1'b1;
         lfsr_en_q     <= 1'b0;
         misr_en_q     <= 1'b0;
         scan_en_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (bus.start) begin
                  num_pat_q     <= bus.num_patterns;
                  golden_q      <= bus.golden;
                  pat_idx_q     <= '0;
                  done_q        <= 1'b0;
                  pass_q        <= 1'b0;
                  busy_q        <= 1'b1;
                  lfsr_seed_n_q <= 1'b0;
                  misr_seed_n_q <= 1'b0;
                  state_q       <= StInit;
               end
            end
            StInit: begin
               lfsr_seed_n_q <= 1'b1;
               misr_seed_n_q <= 1'b1;
               if (num_pat_q == '0) begin
                  state_q <= StCompare;
               end else begin
                  cyc_cnt_q <= '0;
                  lfsr_en_q <= 1'b1;
                  misr_en_q <= 1'b1;
                  scan_en_q <= 1'b1;
                  state_q   <= StShift;
               end
            end
            StShift: begin
               if (cyc_cnt_q == CntLast) begin
                  lfsr_en_q <= 1'b0;
                  misr_en_q <= 1'b0;
                  scan_en_q <= 1'b0;
                  // pat_idx never exceeds num_pat_q, so the full-range count cannot wrap.
                  state_q   <= (pat_idx_q < num_pat_q) ? StCapture : StCompare;
               end else begin
                  cyc_cnt_q <= cyc_cnt_q + CntW'(1);
               end
            end
            StCapture: begin
               pat_idx_q <= pat_idx_q + PAT_W'(1);
               cyc_cnt_q <= '0;
               lfsr_en_q <= 1'b1;
               misr_en_q <= 1'b1;
               scan_en_q <= 1'b1;
               state_q   <= StShift;
            end
            StCompare: begin
               pass_q  <= (bus.misr_sig == golden_q);
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StDone;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.lfsr_seed_n = lfsr_seed_n_q;
   assign bus.misr_seed_n = misr_seed_n_q;
   assign bus.lfsr_en     = lfsr_en_q;
   assign bus.misr_en     = misr_en_q;
   assign bus.scan_en     = scan_en_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.pass        = pass_q;
   assign bus.pat_idx     = pat_idx_q;
endmodule

// File: tb/tb_lbist_ctrl.sv
// Bench for lbist_ctrl: a behavioural MISR drives misr_sig, sessions are checked for latency,
// enable-cycle counts, capture count and pass/fail against a signature computed from first principles.
module tb_lbist_ctrl;
   localparam int unsigned N  = 24;
   localparam int unsigned CL = 4;
   localparam int unsigned PW = 16;
   localparam logic [N-1:0] SEED = N'(100);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned n_pass = 0, n_total = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   lbist_ctrl_if #(.N(N), .PAT_W(PW)) bi ();
   lbist_ctrl #(.N(N), .CHAIN_LEN(CL), .PAT_W(PW)) u_dut (.clk(clk), .rst(rst), .bus(bi));

   lbist_ctrl_if #(.N(8), .PAT_W(4)) bs ();
   lbist_ctrl #(.N(8), .CHAIN_LEN(1), .PAT_W(4)) u_small (.clk(clk), .rst(rst), .bus(bs));

   // Per-step data folded into the MISR; stands in for the scan-chain outputs.
   function automatic logic [N-1:0] mix(input int unsigned k);
      logic [31:0] t;
      t = k * 32'h9E37_79B1 + 32'h1234_5678;
      return t[N-1:0] ^ t[31 -: N];
   endfunction

   // Expected signature: seed, then exactly `steps` enabled compaction cycles.
   function automatic logic [N-1:0] ref_sig(input int unsigned steps);
      logic [N-1:0] s;
      s = SEED;
      for (int unsigned k = 0; k < steps; k++) s = {s[N-2:0], s[N-1]} ^ mix(k);
      return s;
   endfunction

   logic [N-1:0] msig = '0;
   int unsigned  mstep = 0;
   always @(posedge clk) begin
      if (!bi.misr_seed_n) begin
         msig  <= SEED;
         mstep <= 0;
      end else if (bi.misr_en) begin
         msig  <= {msig[N-2:0], msig[N-1]} ^ mix(mstep);
         mstep <= mstep + 1;
      end
   end
   assign bi.misr_sig = msig;

   // Free-running activity counters; sessions compare deltas.
   int unsigned lfsr_cnt = 0, misr_cnt = 0, lseed_cnt = 0, mseed_cnt = 0, scan_low = 0, run = 0;
   bit          seen_hi = 1'b0;
   always @(negedge clk) begin
      if (bi.lfsr_en) lfsr_cnt++;
      if (bi.misr_en) misr_cnt++;
      if (!bi.lfsr_seed_n) lseed_cnt++;
      if (!bi.misr_seed_n) mseed_cnt++;
      if (!bi.busy) begin
         run     = 0;
         seen_hi = 1'b0;
      end else if (bi.scan_en) begin
         if (seen_hi) scan_low += run;
         run     = 0;
         seen_hi = 1'b1;
      end else if (seen_hi) begin
         run++;
      end
   end

   int unsigned l0, m0, ls0, ms0, sl0;

   function automatic logic [7:0] outs();
      return {bi.lfsr_seed_n, bi.misr_seed_n, bi.lfsr_en, bi.misr_en, bi.scan_en,
              bi.busy, bi.done, bi.pass};
   endfunction

   task automatic start_session(input int unsigned p, input logic [N-1:0] g);
      @(negedge clk);
      bi.num_patterns = PW'(p);
      bi.golden       = g;
      bi.start        = 1'b1;
      @(posedge clk);
      #1;
      bi.start = 1'b0;
      l0  = lfsr_cnt;
      m0  = misr_cnt;
      ls0 = lseed_cnt;
      ms0 = mseed_cnt;
      sl0 = scan_low;
      chk("start_busy", bi.busy, 1'b1);
      chk("start_done_clr", bi.done, 1'b0);
      // Latched copies must be used from here on.
      bi.num_patterns = PW'($urandom);
      bi.golden       = N'($urandom);
   endtask

   task automatic run_session(input string tag, input int unsigned p, input logic [N-1:0] g,
                              input int unsigned inj);
      int unsigned edges, steps, lat;
      logic        exp_pass;
      steps    = (p == 0) ? 0 : (p + 1) * CL;
      lat      = (p == 0) ? 2 : 2 + p * (CL + 1) + CL;
      exp_pass = (g == ref_sig(steps));
      start_session(p, g);
      edges = 0;
      while (edges < 3000) begin
         @(posedge clk);
         edges++;
         #1;
         bi.start = (inj != 0) && (edges == inj);
         if (bi.done) break;
      end
      bi.start = 1'b0;
      chk({tag, "_no_timeout"}, (edges < 3000), 1'b1);
      chk({tag, "_latency"}, edges, lat);
      chk({tag, "_done"}, bi.done, 1'b1);
      chk({tag, "_pass"}, bi.pass, exp_pass);
      chk({tag, "_busy"}, bi.busy, 1'b0);
      chk({tag, "_pat_idx"}, bi.pat_idx, PW'(p));
      chk({tag, "_lfsr_en_cyc"}, lfsr_cnt - l0, steps);
      chk({tag, "_misr_en_cyc"}, misr_cnt - m0, steps);
      chk({tag, "_scan_low_cyc"}, scan_low - sl0, p);
      chk({tag, "_lseed_cyc"}, lseed_cnt - ls0, 1);
      chk({tag, "_mseed_cyc"}, mseed_cnt - ms0, 1);
   endtask

   initial begin
      int unsigned edges, p;
      logic [N-1:0] g;
      bi.start = 1'b0; bi.abort = 1'b0; bi.num_patterns = '0; bi.golden = '0;
      bs.start = 1'b0; bs.abort = 1'b0; bs.num_patterns = '0; bs.golden = '0; bs.misr_sig = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", outs(), 8'b1100_0000);
      chk("reset_pat_idx", bi.pat_idx, PW'(0));
      @(negedge clk);
      rst = 1'b0;

      // Passing session with a stray start pulse mid-session.
      run_session("s_pass", 3, ref_sig(16), 5);
      run_session("s_fail", 3, ref_sig(16) ^ N'(1), 0);
      run_session("s_p0", 0, SEED, 0);

      // Abort in DONE clears the result.
      @(negedge clk);
      bi.abort = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_done_clr", {bi.done, bi.pass}, 2'b00);
      @(negedge clk);
      bi.abort = 1'b0;

      // Abort mid-session, then abort+start together in IDLE.
      start_session(3, ref_sig(16));
      repeat (7) @(posedge clk);
      #1;
      bi.abort = 1'b1;
      bi.start = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_outs", outs(), 8'b1100_0000);
      @(posedge clk);
      #1;
      chk("abort_beats_start", outs(), 8'b1100_0000);
      bi.abort = 1'b0;
      bi.start = 1'b0;
      run_session("s_after_abort", 3, ref_sig(16), 0);

      // Synchronous reset mid-session.
      start_session(3, ref_sig(16));
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_outs", outs(), 8'b1100_0000);
      chk("midrst_pat_idx", bi.pat_idx, PW'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         p = $urandom_range(0, 6);
         g = ($urandom_range(0, 1) == 1) ? ref_sig((p == 0) ? 0 : (p + 1) * CL) : N'($urandom);
         run_session("s_rand", p, g, 0);
      end

      // Full-range pattern count on the narrow instance: pat_idx must reach 15 without wrapping.
      @(negedge clk);
      bs.num_patterns = 4'd15;
      bs.golden       = 8'hA5;
      bs.misr_sig     = 8'hA5;
      bs.start        = 1'b1;
      @(posedge clk);
      #1;
      bs.start = 1'b0;
      edges = 0;
      while (edges < 200) begin
         @(posedge clk);
         edges++;
         #1;
         if (bs.done) break;
      end
      chk("small_no_timeout", (edges < 200), 1'b1);
      chk("small_latency", edges, 33);
      chk("small_pat_idx", bs.pat_idx, 4'd15);
      chk("small_pass", bs.pass, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
